argmax_chunk_sched: RTL

- Sequencer that shares one max_byte_index tree (NUM_IN lanes) across a classifier output of NUM_CLASSES scores.
- Scores arrive one byte per beat from the final dense layer and are packed into NUM_IN-byte chunks.
- Each chunk goes through the external tree. The block merges the per-chunk winners into a running maximum and emits the final class index and its score per frame.
- Sits between the last CNN layer and the result/AXI-lite status logic.

---
 rtl/argmax_chunk_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/argmax_chunk_sched.sv
// argmax_chunk_sched
// Packs a frame of NUM_CLASSES byte scores into NUM_IN-byte chunks and runs
// each chunk through one shared external max_byte_index tree. It merges the
// per-chunk winners into a running maximum, where the later class wins ties.
// It then presents the frame's winning class and score on the m_* handshake.
// Optional build macro ARGMAX_SCHED_WDOG_EN: aborts a frame when the tree does
// not answer within WDOG_CYC cycles and raises a sticky err. Without it, err is 0.
module argmax_chunk_sched #(
   parameter  int NUM_CLASSES = 43,
   parameter  int NUM_IN      = 8,
   parameter  int BYTE_W      = 8,
   parameter  int TREE_LAT    = 4,
   parameter  int WDOG_CYC    = 16,
   localparam int IDX_W       = $clog2(NUM_IN),
   localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [BYTE_W-1:0]        s_data,
   output logic                     t_valid,
   output logic [NUM_IN*BYTE_W-1:0] t_data,
   input  logic                     t_o_valid,
   input  logic [IDX_W-1:0]         t_max_idx,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [CLS_W-1:0]         m_class,
   output logic [BYTE_W-1:0]        m_score,
   output logic                     err
);

   localparam int NCHUNK = (NUM_CLASSES + NUM_IN - 1) / NUM_IN;
   localparam int LAST_N = NUM_CLASSES - (NCHUNK - 1) * NUM_IN;
   localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   // The tree latency must match its width, and the watchdog must outlast a
   // normal tree round trip or every frame would be aborted.
   if (TREE_LAT != IDX_W + 1 || WDOG_CYC <= TREE_LAT) begin : g_param_check
      $error("argmax_chunk_sched: inconsistent TREE_LAT / WDOG_CYC");
   end

   typedef enum logic [2:0] {FILL, ISSUE, WAIT, MERGE, OUT} state_t;

   state_t                  state, state_nxt;
   logic [CH_W-1:0]         chunk_cnt;
   logic [IDX_W-1:0]        lane_cnt;
   logic [IDX_W-1:0]        cap_idx;
   logic [BYTE_W-1:0]       buffer [NUM_IN];
   logic [BYTE_W-1:0]       run_val;
   logic [CLS_W-1:0]        run_cls;
   logic                    last_chunk;
   logic                    chunk_full;
   logic                    wdog_trip;
   logic                    padded_win;
   logic [IDX_W-1:0]        cand_idx;
   logic [BYTE_W-1:0]       cand_val;
   logic [CLS_W:0]          cand_cls;

   assign last_chunk = (chunk_cnt == CH_W'(NCHUNK - 1));
   assign chunk_full = last_chunk ? (lane_cnt == IDX_W'(LAST_N - 1))
                                  : (lane_cnt == IDX_W'(NUM_IN - 1));
   assign m_class    = run_cls;
   assign m_score    = run_val;

   // State register.
   // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs.
   // NOTE: every output gets a default before the case, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      t_valid   = 1'b0;
      m_valid   = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            if (s_valid && chunk_full) state_nxt = ISSUE;
         end
         ISSUE: begin
            t_valid   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (t_o_valid)      state_nxt = MERGE;
            else if (wdog_trip) state_nxt = FILL;
         end
         MERGE: state_nxt = last_chunk ? OUT : FILL;
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Flatten the chunk buffer onto the tree data bus.
   always_comb begin
      t_data = '0;
      for (int k = 0; k < NUM_IN; k++) t_data[k*BYTE_W +: BYTE_W] = buffer[k];
   end

   // Candidate from the captured tree index. A padded lane can only win when
   // every real lane is 0, so it maps to the rightmost real lane with value 0.
   always_comb begin
      padded_win = (LAST_N < NUM_IN) && last_chunk && (32'(cap_idx) >= LAST_N);
      cand_idx   = cap_idx;
      cand_val   = buffer[cap_idx];
      if (padded_win) begin
         cand_idx = IDX_W'(LAST_N - 1);
         cand_val = '0;
      end
      cand_cls = (CLS_W+1)'(chunk_cnt) * (CLS_W+1)'(NUM_IN) + (CLS_W+1)'(cand_idx);
   end

   // Datapath: fill lanes, capture the tree index, merge into the running max.
   // NOTE: the buffer is only NUM_IN bytes and padded lanes must read as 0, so it is reset like plain flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chunk_cnt <= '0;
         lane_cnt  <= '0;
         cap_idx   <= '0;
         run_val   <= '0;
         run_cls   <= '0;
         for (int k = 0; k < NUM_IN; k++) buffer[k] <= '0;
      end else begin
         case (state)
            FILL: begin
               if (s_valid) begin
                  buffer[lane_cnt] <= s_data;
                  if (!chunk_full) lane_cnt <= lane_cnt + IDX_W'(1);
               end
            end
            WAIT: begin
               if (t_o_valid) begin
                  cap_idx <= t_max_idx;
               end else if (wdog_trip) begin
                  chunk_cnt <= '0;
                  lane_cnt  <= '0;
                  for (int k = 0; k < NUM_IN; k++) buffer[k] <= '0;
               end
            end
            MERGE: begin
               if (chunk_cnt == '0 || cand_val >= run_val) begin
                  run_val <= cand_val;
                  run_cls <= CLS_W'(cand_cls);
               end
               if (!last_chunk) begin
                  chunk_cnt <= chunk_cnt + CH_W'(1);
                  lane_cnt  <= '0;
               end
               // Start the next chunk from zeros so unused last-chunk lanes are 0.
               for (int k = 0; k < NUM_IN; k++) buffer[k] <= '0;
            end
            OUT: begin
               if (m_ready) begin
                  chunk_cnt <= '0;
                  lane_cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ARGMAX_SCHED_WDOG_EN
   localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

   logic [WD_W-1:0] wdog_cnt;
   logic            err_q;

   assign wdog_trip = (state == WAIT) && !t_o_valid && (wdog_cnt == WD_W'(WDOG_CYC - 1));
   assign err       = err_q;

   // Watchdog: count cycles spent in WAIT; the error stays set until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == WAIT) wdog_cnt <= wdog_cnt + WD_W'(1);
         else               wdog_cnt <= '0;
         if (wdog_trip) err_q <= 1'b1;
      end
   end
`else
   assign wdog_trip = 1'b0;
   assign err       = 1'b0;
`endif

endmodule
